mmu_rsp_collector: RTL and testbench
====================================

Name: mmu_rsp_collector

Overview:
Return path of the MMU request pipeline. Merges two alloc-response sources into the alloc rsp fifo: the dispatcher's early-reject responses and the fdt allocation results. Merges two free-response sources into the free rsp fifo the same way: dispatcher rejects and or_tree free completions. Sources are fire-and-forget pulses with no backpressure, so each channel buffers responses in a small queue that accepts 2 writes and 1 read per cycle, and drains in order whenever the fifo is not full.

Parameters:
PEND_DEPTH, 4, entries per channel queue (power of 2, ≥2)
PEND_PTR_WIDTH, 2, log2(PEND_DEPTH)

Ports:
clk  in  1  clock
rst_n  in  1  async active-low reset
disp_alloc_valid  in  1  dispatcher alloc reject pulse
disp_alloc_id/page_idx/fail/fail_reason  in  `REQ_ID_WIDTH/`ALL_PAGE_IDX_WIDTH/1/`FAIL_REASON_WIDTH  dispatcher alloc rsp fields
fdt_alloc_valid  in  1  fdt alloc result pulse
fdt_alloc_id/page_idx/fail/fail_reason  in  same widths  fdt result fields
alloc_rsp_write_en  out  1  write strobe to alloc rsp fifo
alloc_rsp_id/page_idx/fail/fail_reason  out  same widths  alloc rsp fifo data
alloc_rsp_fifo_full  in  1  alloc rsp fifo full
disp_free_valid  in  1  dispatcher free reject pulse
disp_free_id/fail/fail_reason  in  `REQ_ID_WIDTH/1/`FAIL_REASON_WIDTH  fields
or_tree_free_valid  in  1  or_tree free completion pulse
or_tree_free_id/fail/fail_reason  in  same widths  fields
free_rsp_write_en  out  1  write strobe to free rsp fifo
free_rsp_id/fail/fail_reason  out  same widths  free rsp fifo data
free_rsp_fifo_full  in  1  free rsp fifo full
err_clr  in  1  clears sticky overflow flags
alloc_overflow, free_overflow  out  1 each  sticky: a response was dropped
alloc_pend_count, free_pend_count  out  PEND_PTR_WIDTH+1  current queue occupancy

Behaviour:
- Reset: all outputs 0; queues empty, pointers 0, overflow flags 0.
- Both channels are identical; the free channel omits page_idx. The two channels are fully independent.
- Enqueue per cycle: up to 2 entries. When both sources fire in the same cycle, the disp entry is written first (lower slot), then the engine entry.
- Drain: in any cycle where the queue is non-empty and fifo_full=0, pop the head and register it to the outputs. write_en=1 for exactly that next cycle; data holds the popped entry. When write_en=0, data fields are 0.
- Latency: an input at cycle N into an empty queue with fifo not full gives write_en at N+1. This is a same-cycle bypass through the queue head; no combinational path exists from inputs to outputs.
- Ordering: strict FIFO per channel.
- Occupancy: next = count + enq − deq, and a deq at the same cycle frees a slot for that cycle's enq. Pointers wrap modulo PEND_DEPTH.
- Overflow: if count − deq + enq > PEND_DEPTH, accept entries in priority order (disp first) until full and drop the rest. Set the sticky flag the next cycle. Never corrupt queued entries.
- err_clr: clears the flag. If a drop happens in the same cycle as err_clr, the set wins.
- fifo_full held: the queue holds its contents and write_en stays 0. Drain resumes the cycle after full deasserts.
- Asserting rst_n low mid-operation flushes the queues immediately (asynchronously) and returns everything to reset values.
- alloc_rsp_fifo_almost_full is not consumed by this block; the dispatcher owns it.

Decomposition:
- Reuse `REQ_ID_WIDTH, `ALL_PAGE_IDX_WIDTH and `FAIL_REASON_WIDTH from src/mmu_param.vh.
- Add `RSP_PEND_DEPTH (default 4) to mmu_param.vh.
- Sub-module rsp_pend_queue: 2-write/1-read queue parameterised by DATA_WIDTH and PEND_DEPTH, with count and overflow outputs. It is instantiated twice: alloc with fields packed {id, page_idx, fail, reason}; free with {id, fail, reason}.
- Top level handles field packing, output registers and sticky flags.

Test Plan:
1. fdt_alloc_valid pulse with id=5, page_idx=0x123, fail=0; fifo not full -> next cycle alloc_rsp_write_en=1, id=5, page_idx=0x123, fail=0; the cycle after, write_en=0.
2. disp_alloc (id=1, fail=1, reason=EQUAL_ZERO) and fdt_alloc (id=2) in the same cycle -> two consecutive writes, id=1 then id=2; alloc_pend_count peaks at 1 after the first drain.
3. alloc_rsp_fifo_full=1; 4 single fdt pulses id=10..13 -> no writes, count=4; release full -> writes 10, 11, 12, 13 on 4 consecutive cycles.
4. Queue full (4 entries, fifo full), then disp+fdt pulse in the same cycle -> both dropped, alloc_overflow=1 next cycle; queue contents unchanged; err_clr -> flag 0.
5. Free channel: or_tree id=7 and disp id=8 (fail=1, reason=OVER_4KB) simultaneously, with an alloc burst on the alloc channel -> free writes 8 then 7; alloc channel unaffected.
6. rst_n asserted with 3 pending entries -> write_en=0 and count=0 immediately; no stale writes after reset release.

Source files
------------

// File: rtl/mmu_rsp_collector_pkg.sv
// Shared widths, response records and fail-reason codes for the MMU response return path.
package mmu_rsp_collector_pkg;

  localparam int REQ_ID_WIDTH       = 8;
  localparam int ALL_PAGE_IDX_WIDTH = 12;
  localparam int FAIL_REASON_WIDTH  = 3;
  localparam int RSP_PEND_DEPTH     = 4;

  typedef enum logic [FAIL_REASON_WIDTH-1:0] {
    FR_NONE       = 3'd0,
    FR_EQUAL_ZERO = 3'd1,
    FR_OVER_4KB   = 3'd2,
    FR_NO_SPACE   = 3'd3,
    FR_BAD_ID     = 3'd4
  } fail_reason_e;

  typedef struct packed {
    logic [REQ_ID_WIDTH-1:0]       id;
    logic [ALL_PAGE_IDX_WIDTH-1:0] page_idx;
    logic                          fail;
    logic [FAIL_REASON_WIDTH-1:0]  reason;
  } alloc_rsp_t;

  typedef struct packed {
    logic [REQ_ID_WIDTH-1:0]      id;
    logic                         fail;
    logic [FAIL_REASON_WIDTH-1:0] reason;
  } free_rsp_t;

endpackage

// File: rtl/mmu_rsp_collector_if.sv
// Source pulses, rsp-fifo write ports and status of the response collector.
interface mmu_rsp_collector_if
  import mmu_rsp_collector_pkg::*;
#(
  parameter int PEND_PTR_WIDTH = $clog2(RSP_PEND_DEPTH)
);
  logic                          disp_alloc_valid;
  logic [REQ_ID_WIDTH-1:0]       disp_alloc_id;
  logic [ALL_PAGE_IDX_WIDTH-1:0] disp_alloc_page_idx;
  logic                          disp_alloc_fail;
  logic [FAIL_REASON_WIDTH-1:0]  disp_alloc_fail_reason;
  logic                          fdt_alloc_valid;
  logic [REQ_ID_WIDTH-1:0]       fdt_alloc_id;
  logic [ALL_PAGE_IDX_WIDTH-1:0] fdt_alloc_page_idx;
  logic                          fdt_alloc_fail;
  logic [FAIL_REASON_WIDTH-1:0]  fdt_alloc_fail_reason;
  logic                          alloc_rsp_write_en;
  logic [REQ_ID_WIDTH-1:0]       alloc_rsp_id;
  logic [ALL_PAGE_IDX_WIDTH-1:0] alloc_rsp_page_idx;
  logic                          alloc_rsp_fail;
  logic [FAIL_REASON_WIDTH-1:0]  alloc_rsp_fail_reason;
  logic                          alloc_rsp_fifo_full;

  logic                          disp_free_valid;
  logic [REQ_ID_WIDTH-1:0]       disp_free_id;
  logic                          disp_free_fail;
  logic [FAIL_REASON_WIDTH-1:0]  disp_free_fail_reason;
  logic                          or_tree_free_valid;
  logic [REQ_ID_WIDTH-1:0]       or_tree_free_id;
  logic                          or_tree_free_fail;
  logic [FAIL_REASON_WIDTH-1:0]  or_tree_free_fail_reason;
  logic                          free_rsp_write_en;
  logic [REQ_ID_WIDTH-1:0]       free_rsp_id;
  logic                          free_rsp_fail;
  logic [FAIL_REASON_WIDTH-1:0]  free_rsp_fail_reason;
  logic                          free_rsp_fifo_full;

  logic                          err_clr;
  logic                          alloc_overflow;
  logic                          free_overflow;
  logic [PEND_PTR_WIDTH:0]       alloc_pend_count;
  logic [PEND_PTR_WIDTH:0]       free_pend_count;

  modport slave (
    input  disp_alloc_valid, disp_alloc_id, disp_alloc_page_idx, disp_alloc_fail, disp_alloc_fail_reason,
    input  fdt_alloc_valid, fdt_alloc_id, fdt_alloc_page_idx, fdt_alloc_fail, fdt_alloc_fail_reason,
    input  alloc_rsp_fifo_full,
    output alloc_rsp_write_en, alloc_rsp_id, alloc_rsp_page_idx, alloc_rsp_fail, alloc_rsp_fail_reason,
    input  disp_free_valid, disp_free_id, disp_free_fail, disp_free_fail_reason,
    input  or_tree_free_valid, or_tree_free_id, or_tree_free_fail, or_tree_free_fail_reason,
    input  free_rsp_fifo_full,
    output free_rsp_write_en, free_rsp_id, free_rsp_fail, free_rsp_fail_reason,
    input  err_clr,
    output alloc_overflow, free_overflow, alloc_pend_count, free_pend_count
  );

  modport master (
    output disp_alloc_valid, disp_alloc_id, disp_alloc_page_idx, disp_alloc_fail, disp_alloc_fail_reason,
    output fdt_alloc_valid, fdt_alloc_id, fdt_alloc_page_idx, fdt_alloc_fail, fdt_alloc_fail_reason,
    output alloc_rsp_fifo_full,
    input  alloc_rsp_write_en, alloc_rsp_id, alloc_rsp_page_idx, alloc_rsp_fail, alloc_rsp_fail_reason,
    output disp_free_valid, disp_free_id, disp_free_fail, disp_free_fail_reason,
    output or_tree_free_valid, or_tree_free_id, or_tree_free_fail, or_tree_free_fail_reason,
    output free_rsp_fifo_full,
    input  free_rsp_write_en, free_rsp_id, free_rsp_fail, free_rsp_fail_reason,
    output err_clr,
    input  alloc_overflow, free_overflow, alloc_pend_count, free_pend_count
  );
endinterface

// File: rtl/mmu_rsp_collector_rsp_pend_queue.sv
// 2-write/1-read pending queue; accepted writes always land in memory, and the head
// bypasses same-cycle writes when empty so a lone pulse drains without an extra cycle.
module rsp_pend_queue #(
  parameter int DATA_WIDTH = 8,
  parameter int PEND_DEPTH = 4,
  localparam int PW = $clog2(PEND_DEPTH)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  i_wr0_vld,
  input  logic [DATA_WIDTH-1:0] i_wr0_data,
  input  logic                  i_wr1_vld,
  input  logic [DATA_WIDTH-1:0] i_wr1_data,
  input  logic                  i_full,
  output logic                  o_pop,
  output logic [DATA_WIDTH-1:0] o_head,
  output logic [PW:0]           o_count,
  output logic                  o_drop
);
  logic [DATA_WIDTH-1:0] r_mem [PEND_DEPTH];
  logic [PW-1:0]         r_wr_ptr, r_rd_ptr;
  logic [PW:0]           r_count;
  logic                  w_empty, w_acc0, w_acc1;
  logic [PW:0]           w_free, w_nacc;

  // A pop from a non-empty queue never depends on this cycle's writes, so it can
  // free a slot for them without a combinational loop.
  assign w_empty = (r_count == '0);
  assign w_free  = (PW+1)'(PEND_DEPTH) - r_count + (PW+1)'(!w_empty && !i_full);
  assign w_acc0  = i_wr0_vld && (w_free != '0);
  assign w_acc1  = i_wr1_vld && (w_free > (PW+1)'(w_acc0));
  assign w_nacc  = (PW+1)'(w_acc0) + (PW+1)'(w_acc1);
  assign o_pop   = !i_full && (!w_empty || w_acc0 || w_acc1);
  assign o_head  = !w_empty ? r_mem[r_rd_ptr] : (w_acc0 ? i_wr0_data : i_wr1_data);
  assign o_drop  = (i_wr0_vld && !w_acc0) || (i_wr1_vld && !w_acc1);
  assign o_count = r_count;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
      for (int i = 0; i < PEND_DEPTH; i++) r_mem[i] <= '0;
    end else begin
      if (w_acc0) r_mem[r_wr_ptr] <= i_wr0_data;
      if (w_acc1) r_mem[r_wr_ptr + PW'(w_acc0)] <= i_wr1_data;
      r_wr_ptr <= r_wr_ptr + w_nacc[PW-1:0];
      r_rd_ptr <= r_rd_ptr + PW'(o_pop);
      r_count  <= r_count + w_nacc - (PW+1)'(o_pop);
    end
  end
endmodule

// File: rtl/mmu_rsp_collector.sv
// Merges dispatcher rejects with fdt/or_tree results into the alloc and free rsp fifos.
module mmu_rsp_collector
  import mmu_rsp_collector_pkg::*;
#(
  parameter int PEND_DEPTH     = RSP_PEND_DEPTH,
  parameter int PEND_PTR_WIDTH = $clog2(PEND_DEPTH)
) (
  input  logic                 clk,
  input  logic                 rst_n,
  mmu_rsp_collector_if.slave   bus
);
  alloc_rsp_t              w_a_disp, w_a_fdt, w_a_head, r_a_data;
  free_rsp_t               w_f_disp, w_f_ort, w_f_head, r_f_data;
  logic                    w_a_pop, w_a_drop, w_f_pop, w_f_drop;
  logic                    r_a_we, r_f_we, r_a_ovf, r_f_ovf;
  logic [PEND_PTR_WIDTH:0] w_a_count, w_f_count;

  assign w_a_disp = '{id: bus.disp_alloc_id, page_idx: bus.disp_alloc_page_idx,
                      fail: bus.disp_alloc_fail, reason: bus.disp_alloc_fail_reason};
  assign w_a_fdt  = '{id: bus.fdt_alloc_id, page_idx: bus.fdt_alloc_page_idx,
                      fail: bus.fdt_alloc_fail, reason: bus.fdt_alloc_fail_reason};
  assign w_f_disp = '{id: bus.disp_free_id, fail: bus.disp_free_fail,
                      reason: bus.disp_free_fail_reason};
  assign w_f_ort  = '{id: bus.or_tree_free_id, fail: bus.or_tree_free_fail,
                      reason: bus.or_tree_free_fail_reason};

  rsp_pend_queue #(.DATA_WIDTH($bits(alloc_rsp_t)), .PEND_DEPTH(PEND_DEPTH)) u_alloc_q (
    .clk, .rst_n,
    .i_wr0_vld (bus.disp_alloc_valid), .i_wr0_data(w_a_disp),
    .i_wr1_vld (bus.fdt_alloc_valid),  .i_wr1_data(w_a_fdt),
    .i_full    (bus.alloc_rsp_fifo_full),
    .o_pop     (w_a_pop), .o_head(w_a_head), .o_count(w_a_count), .o_drop(w_a_drop)
  );

  rsp_pend_queue #(.DATA_WIDTH($bits(free_rsp_t)), .PEND_DEPTH(PEND_DEPTH)) u_free_q (
    .clk, .rst_n,
    .i_wr0_vld (bus.disp_free_valid),    .i_wr0_data(w_f_disp),
    .i_wr1_vld (bus.or_tree_free_valid), .i_wr1_data(w_f_ort),
    .i_full    (bus.free_rsp_fifo_full),
    .o_pop     (w_f_pop), .o_head(w_f_head), .o_count(w_f_count), .o_drop(w_f_drop)
  );

  // Data is zeroed on idle cycles so the fifo never sees stale fields; a drop beats err_clr.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_a_we   <= 1'b0;
      r_a_data <= '0;
      r_a_ovf  <= 1'b0;
      r_f_we   <= 1'b0;
      r_f_data <= '0;
      r_f_ovf  <= 1'b0;
    end else begin
      r_a_we   <= w_a_pop;
      r_a_data <= w_a_pop ? w_a_head : '0;
      r_a_ovf  <= w_a_drop | (r_a_ovf & ~bus.err_clr);
      r_f_we   <= w_f_pop;
      r_f_data <= w_f_pop ? w_f_head : '0;
      r_f_ovf  <= w_f_drop | (r_f_ovf & ~bus.err_clr);
    end
  end

  assign bus.alloc_rsp_write_en    = r_a_we;
  assign bus.alloc_rsp_id          = r_a_data.id;
  assign bus.alloc_rsp_page_idx    = r_a_data.page_idx;
  assign bus.alloc_rsp_fail        = r_a_data.fail;
  assign bus.alloc_rsp_fail_reason = r_a_data.reason;
  assign bus.free_rsp_write_en     = r_f_we;
  assign bus.free_rsp_id           = r_f_data.id;
  assign bus.free_rsp_fail         = r_f_data.fail;
  assign bus.free_rsp_fail_reason  = r_f_data.reason;
  assign bus.alloc_overflow        = r_a_ovf;
  assign bus.free_overflow         = r_f_ovf;
  assign bus.alloc_pend_count      = w_a_count;
  assign bus.free_pend_count       = w_f_count;
endmodule

// File: tb/tb_mmu_rsp_collector.sv
// Bench for mmu_rsp_collector: queue-based reference model checked every cycle, plus literal pins.
module tb_mmu_rsp_collector;
  import mmu_rsp_collector_pkg::*;

  localparam int AW    = $bits(alloc_rsp_t);
  localparam int DEPTH = RSP_PEND_DEPTH;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   n_cmp = 0;
  int   n_err = 0;

  mmu_rsp_collector_if bus ();

  mmu_rsp_collector dut (.clk(clk), .rst_n(rst_n), .bus(bus));

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s actual=%0h required=%0h t=%0t", nm, act, exp, $time);
    end
  endtask

  function automatic logic [AW-1:0] pk(input int id, input int pg, input logic f, input int r);
    return {REQ_ID_WIDTH'(id), ALL_PAGE_IDX_WIDTH'(pg), f, FAIL_REASON_WIDTH'(r)};
  endfunction

  // Reference: pop the old head if allowed, push sources in disp-then-engine order while
  // there is room, and if the queue started empty let the first new entry leave at once.
  logic [AW-1:0] mqa[$];
  logic [AW-1:0] mqf[$];
  logic          e_awe = 0, e_fwe = 0, e_aovf = 0, e_fovf = 0;
  logic [AW-1:0] e_ad = '0, e_fd = '0;
  int            e_acnt = 0, e_fcnt = 0;

  task automatic model_ch(ref logic [AW-1:0] q[$], input logic v0, input logic [AW-1:0] d0,
                          input logic v1, input logic [AW-1:0] d1, input logic full,
                          input logic ovf_in, output logic we, output logic [AW-1:0] d,
                          output int cnt, output logic ovf);
    logic dropped;
    we = 0; d = '0; dropped = 0;
    if (!full && q.size() > 0) begin d = q.pop_front(); we = 1; end
    if (v0) begin if (q.size() < DEPTH) q.push_back(d0); else dropped = 1; end
    if (v1) begin if (q.size() < DEPTH) q.push_back(d1); else dropped = 1; end
    if (!full && !we && q.size() > 0) begin d = q.pop_front(); we = 1; end
    cnt = q.size();
    ovf = dropped | (ovf_in & ~bus.err_clr);
  endtask

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mqa.delete(); mqf.delete();
      e_awe = 0; e_fwe = 0; e_aovf = 0; e_fovf = 0;
      e_ad = '0; e_fd = '0; e_acnt = 0; e_fcnt = 0;
    end else begin
      model_ch(mqa, bus.disp_alloc_valid,
               pk(bus.disp_alloc_id, bus.disp_alloc_page_idx, bus.disp_alloc_fail, bus.disp_alloc_fail_reason),
               bus.fdt_alloc_valid,
               pk(bus.fdt_alloc_id, bus.fdt_alloc_page_idx, bus.fdt_alloc_fail, bus.fdt_alloc_fail_reason),
               bus.alloc_rsp_fifo_full, e_aovf, e_awe, e_ad, e_acnt, e_aovf);
      model_ch(mqf, bus.disp_free_valid,
               pk(bus.disp_free_id, 0, bus.disp_free_fail, bus.disp_free_fail_reason),
               bus.or_tree_free_valid,
               pk(bus.or_tree_free_id, 0, bus.or_tree_free_fail, bus.or_tree_free_fail_reason),
               bus.free_rsp_fifo_full, e_fovf, e_fwe, e_fd, e_fcnt, e_fovf);
    end
  end

  always @(negedge clk) begin
    chk("alloc_we",    64'(bus.alloc_rsp_write_en), 64'(e_awe));
    chk("alloc_data",  64'(pk(bus.alloc_rsp_id, bus.alloc_rsp_page_idx, bus.alloc_rsp_fail,
                             bus.alloc_rsp_fail_reason)), 64'(e_ad));
    chk("alloc_count", 64'(bus.alloc_pend_count), 64'(e_acnt));
    chk("alloc_ovf",   64'(bus.alloc_overflow), 64'(e_aovf));
    chk("free_we",     64'(bus.free_rsp_write_en), 64'(e_fwe));
    chk("free_data",   64'(pk(bus.free_rsp_id, 0, bus.free_rsp_fail, bus.free_rsp_fail_reason)), 64'(e_fd));
    chk("free_count",  64'(bus.free_pend_count), 64'(e_fcnt));
    chk("free_ovf",    64'(bus.free_overflow), 64'(e_fovf));
  end

  task automatic tick();
    @(negedge clk);
    bus.disp_alloc_valid = 0; bus.fdt_alloc_valid = 0;
    bus.disp_free_valid = 0;  bus.or_tree_free_valid = 0;
    bus.err_clr = 0;
  endtask

  task automatic disp_a(input int id, input logic f, input int r);
    bus.disp_alloc_valid = 1; bus.disp_alloc_id = REQ_ID_WIDTH'(id);
    bus.disp_alloc_page_idx = '0; bus.disp_alloc_fail = f;
    bus.disp_alloc_fail_reason = FAIL_REASON_WIDTH'(r);
  endtask

  task automatic fdt_a(input int id, input int pg);
    bus.fdt_alloc_valid = 1; bus.fdt_alloc_id = REQ_ID_WIDTH'(id);
    bus.fdt_alloc_page_idx = ALL_PAGE_IDX_WIDTH'(pg); bus.fdt_alloc_fail = 0;
    bus.fdt_alloc_fail_reason = '0;
  endtask

  task automatic disp_f(input int id, input logic f, input int r);
    bus.disp_free_valid = 1; bus.disp_free_id = REQ_ID_WIDTH'(id);
    bus.disp_free_fail = f; bus.disp_free_fail_reason = FAIL_REASON_WIDTH'(r);
  endtask

  task automatic ort_f(input int id);
    bus.or_tree_free_valid = 1; bus.or_tree_free_id = REQ_ID_WIDTH'(id);
    bus.or_tree_free_fail = 0; bus.or_tree_free_fail_reason = '0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.disp_alloc_valid = 0; bus.disp_alloc_id = '0; bus.disp_alloc_page_idx = '0;
    bus.disp_alloc_fail = 0; bus.disp_alloc_fail_reason = '0;
    bus.fdt_alloc_valid = 0; bus.fdt_alloc_id = '0; bus.fdt_alloc_page_idx = '0;
    bus.fdt_alloc_fail = 0; bus.fdt_alloc_fail_reason = '0;
    bus.disp_free_valid = 0; bus.disp_free_id = '0; bus.disp_free_fail = 0;
    bus.disp_free_fail_reason = '0;
    bus.or_tree_free_valid = 0; bus.or_tree_free_id = '0; bus.or_tree_free_fail = 0;
    bus.or_tree_free_fail_reason = '0;
    bus.alloc_rsp_fifo_full = 0; bus.free_rsp_fifo_full = 0; bus.err_clr = 0;

    tick(); tick();
    chk("rst_alloc_we", 64'(bus.alloc_rsp_write_en), 64'd0);
    chk("rst_alloc_cnt", 64'(bus.alloc_pend_count), 64'd0);
    chk("rst_alloc_ovf", 64'(bus.alloc_overflow), 64'd0);
    rst_n = 1;
    tick();

    // single fdt pulse: one-cycle latency
    fdt_a(5, 'h123); tick();
    chk("t1_we", 64'(bus.alloc_rsp_write_en), 64'd1);
    chk("t1_id", 64'(bus.alloc_rsp_id), 64'd5);
    chk("t1_pg", 64'(bus.alloc_rsp_page_idx), 64'h123);
    tick();
    chk("t1_we_off", 64'(bus.alloc_rsp_write_en), 64'd0);

    // disp and fdt together: disp first
    disp_a(1, 1, FR_EQUAL_ZERO); fdt_a(2, 0); tick();
    chk("t2_id0", 64'(bus.alloc_rsp_id), 64'd1);
    chk("t2_rsn", 64'(bus.alloc_rsp_fail_reason), 64'(FR_EQUAL_ZERO));
    chk("t2_cnt", 64'(bus.alloc_pend_count), 64'd1);
    tick();
    chk("t2_id1", 64'(bus.alloc_rsp_id), 64'd2);
    chk("t2_cnt0", 64'(bus.alloc_pend_count), 64'd0);
    tick();

    // fifo full hold then burst drain
    bus.alloc_rsp_fifo_full = 1;
    for (int i = 0; i < 4; i++) begin fdt_a(10 + i, i); tick(); end
    chk("t3_cnt", 64'(bus.alloc_pend_count), 64'd4);
    chk("t3_we", 64'(bus.alloc_rsp_write_en), 64'd0);
    bus.alloc_rsp_fifo_full = 0;
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("t3_id", 64'(bus.alloc_rsp_id), 64'(10 + i));
      chk("t3_cnt_dn", 64'(bus.alloc_pend_count), 64'(3 - i));
    end
    tick();

    // overflow: both dropped, set wins over err_clr, then clear
    bus.alloc_rsp_fifo_full = 1;
    for (int i = 0; i < 4; i++) begin fdt_a(20 + i, 0); tick(); end
    disp_a(24, 0, 0); fdt_a(25, 0); tick();
    chk("t4_ovf", 64'(bus.alloc_overflow), 64'd1);
    chk("t4_cnt", 64'(bus.alloc_pend_count), 64'd4);
    disp_a(26, 0, 0); bus.err_clr = 1; tick();
    chk("t4_ovf_setwins", 64'(bus.alloc_overflow), 64'd1);
    bus.err_clr = 1; tick();
    chk("t4_ovf_clr", 64'(bus.alloc_overflow), 64'd0);
    bus.alloc_rsp_fifo_full = 0;
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("t4_id", 64'(bus.alloc_rsp_id), 64'(20 + i));
    end
    tick();

    // free channel alongside an alloc burst
    ort_f(7); disp_f(8, 1, FR_OVER_4KB); fdt_a(30, 3); disp_a(31, 1, FR_NO_SPACE); tick();
    chk("t5_fid0", 64'(bus.free_rsp_id), 64'd8);
    chk("t5_frsn", 64'(bus.free_rsp_fail_reason), 64'(FR_OVER_4KB));
    chk("t5_aid0", 64'(bus.alloc_rsp_id), 64'd31);
    tick();
    chk("t5_fid1", 64'(bus.free_rsp_id), 64'd7);
    chk("t5_aid1", 64'(bus.alloc_rsp_id), 64'd30);
    tick();

    // mixed directed pattern with intermittent fifo full
    for (int i = 0; i < 30; i++) begin
      if (i % 3 == 0) disp_a(50 + i, 1, 1);
      if (i % 2 == 0) fdt_a(100 + i, i * 7);
      if (i % 4 == 1) disp_f(i, 1, 2);
      if (i % 3 != 2) ort_f(150 + i);
      bus.alloc_rsp_fifo_full = (i % 7 >= 4);
      bus.free_rsp_fifo_full  = (i % 5 == 3);
      bus.err_clr = (i == 20);
      tick();
    end
    bus.alloc_rsp_fifo_full = 0; bus.free_rsp_fifo_full = 0;
    repeat (8) tick();

    // async reset mid-drain
    bus.alloc_rsp_fifo_full = 1;
    for (int i = 0; i < 3; i++) begin fdt_a(40 + i, 0); tick(); end
    bus.alloc_rsp_fifo_full = 0;
    tick();
    chk("t6_pre_we", 64'(bus.alloc_rsp_write_en), 64'd1);
    chk("t6_pre_cnt", 64'(bus.alloc_pend_count), 64'd2);
    #2 rst_n = 0;
    #1;
    chk("t6_we", 64'(bus.alloc_rsp_write_en), 64'd0);
    chk("t6_cnt", 64'(bus.alloc_pend_count), 64'd0);
    tick();
    #2 rst_n = 1;
    repeat (4) tick();
    chk("t6_post_we", 64'(bus.alloc_rsp_write_en), 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
